// File: rtl/jk_bank_controller.sv
// jk_bank_controller: sequences J/K vectors into a bank of WIDTH JK flip-flops from valid/ready commands.
// Define JK_BANK_CTRL_ABORT_EN to add an abort input that ends a COUNT early.
module jk_bank_controller #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
`ifdef JK_BANK_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, EXEC, COUNT, DONE} state_t;
    localparam logic [2:0] OP_CLR = 3'd1, OP_SET = 3'd2, OP_TGL = 3'd3, OP_LD = 3'd4,
                           OP_UP = 3'd5, OP_DN = 3'd6, OP_RSV = 3'd7;
    state_t state, next;
    logic [2:0] op_r;
    logic [WIDTH-1:0] data_r, up_t, dn_t;
    logic [CNT_W-1:0] cnt;
    logic is_cnt, abort_hit;
`ifdef JK_BANK_CTRL_ABORT_EN
    assign abort_hit = abort && state == COUNT;
`else
    assign abort_hit = 1'b0;
`endif
    assign is_cnt = (cmd_op == OP_UP || cmd_op == OP_DN) && cmd_len != '0;
    assign cmd_ready = state == IDLE;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign err = done && op_r == OP_RSV;
    assign q_bar = ~q;
    // toggle chains: bit i flips when all lower bits are 1 (up) or all 0 (down)
    always_comb begin
        up_t = '0;
        dn_t = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & q[i-1];
            dn_t[i] = dn_t[i-1] & ~q[i-1];
        end
    end
    always_comb begin
        next = state;
        j_out = '0;
        k_out = '0;
        case (state)
            IDLE: next = cmd_valid ? (is_cnt ? COUNT : EXEC) : IDLE;
            EXEC: begin
                next = DONE;
                case (op_r)
                    OP_CLR: k_out = '1;
                    OP_SET: j_out = '1;
                    OP_TGL: begin
                        j_out = data_r;
                        k_out = data_r;
                    end
                    OP_LD: begin
                        j_out = data_r;
                        k_out = ~data_r;
                    end
                    default: ;
                endcase
            end
            COUNT: begin
                next = (abort_hit || cnt == CNT_W'(1)) ? DONE : COUNT;
                j_out = abort_hit ? '0 : (op_r == OP_UP ? up_t : dn_t);
                k_out = j_out;
            end
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q <= '0;
            op_r <= '0;
            data_r <= '0;
            cnt <= '0;
        end else begin
            state <= next;
            q <= (j_out & ~q) | (~k_out & q);
            if (state == IDLE && cmd_valid) begin
                op_r <= cmd_op;
                data_r <= cmd_data;
                cnt <= cmd_len;
            end else if (state == COUNT) begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jk_bank_controller.sv
// tb_jk_bank_controller: directed and randomized checks of jk_bank_controller against an arithmetic bank model.
// Define JK_BANK_CTRL_ABORT_EN to also exercise the abort input.
module tb_jk_bank_controller;
    localparam logic [2:0] NOP = 3'd0, CLR = 3'd1, SET = 3'd2, TGL = 3'd3, LD = 3'd4,
                           UP = 3'd5, DN = 3'd6, RSV = 3'd7;
    logic clk, rst, cmd_valid, cmd_ready, busy, done, err;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data, j_out, k_out, q, q_bar, mq;
    logic [7:0] cmd_len;
`ifdef JK_BANK_CTRL_ABORT_EN
    logic abort;
`endif
    int vectors = 0, miscompares = 0;

    jk_bank_controller #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
`ifdef JK_BANK_CTRL_ABORT_EN
        .abort(abort),
`endif
        .j_out(j_out), .k_out(k_out), .q(q), .q_bar(q_bar),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model(input logic [3:0] cur, input logic [2:0] op,
                                         input logic [3:0] d, input logic [7:0] len);
        case (op)
            CLR: return 4'd0;
            SET: return 4'hF;
            TGL: return cur ^ d;
            LD: return d;
            UP: return 4'((int'(cur) + int'(len)) % 16);
            DN: return 4'((int'(cur) - int'(len) % 16 + 16) % 16);
            default: return cur;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [7:0] len);
        return ((op == UP || op == DN) && len != 0) ? int'(len) + 1 : 2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] d, input logic [7:0] len);
        int w = 0;
        while (cmd_ready !== 1'b1 && w < 10) begin step(); w++; end
        cmd_valid = 1; cmd_op = op; cmd_data = d; cmd_len = len;
        step();
        cmd_valid = 0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 300) begin step(); cyc++; end
    endtask

    task automatic test_reset();
        rst = 1;
        step(); step();
        vectors++; if (q !== 4'h0 || q_bar !== 4'hF) begin miscompares++; $display("FAIL reset_q got q=%b q_bar=%b want 0000/1111", q, q_bar); end
        vectors++; if ({cmd_ready, busy, done, err} !== 4'b1000 || j_out !== 0 || k_out !== 0) begin miscompares++; $display("FAIL reset_ctl got rdy/busy/done/err=%b j=%b k=%b want 1000 0 0", {cmd_ready, busy, done, err}, j_out, k_out); end
        rst = 0;
        mq = 0;
        step();
    endtask

    task automatic test_load_toggle();
        int c;
        send(LD, 4'b1010, 0); wait_done(c); mq = model(mq, LD, 4'b1010, 0);
        vectors++; if (q !== 4'b1010 || c !== 2) begin miscompares++; $display("FAIL load got q=%b lat=%0d want 1010 lat=2", q, c); end
        step();
        send(TGL, 4'b0110, 0); wait_done(c); mq = model(mq, TGL, 4'b0110, 0);
        vectors++; if (q !== mq || q_bar !== ~mq || c !== 2) begin miscompares++; $display("FAIL toggle got q=%b q_bar=%b lat=%0d want %b/%b lat=2", q, q_bar, c, mq, ~mq); end
        step();
    endtask

    task automatic test_set_clear();
        int c;
        send(SET, 0, 0);
        vectors++; if (j_out !== 4'hF || k_out !== 4'h0) begin miscompares++; $display("FAIL set_jk got j=%b k=%b want 1111/0000", j_out, k_out); end
        step();
        vectors++; if (j_out !== 0 || k_out !== 0 || q !== 4'hF || done !== 1) begin miscompares++; $display("FAIL set_after got j=%b k=%b q=%b done=%b want 0/0/1111/1", j_out, k_out, q, done); end
        step();
        send(CLR, 0, 0);
        vectors++; if (j_out !== 4'h0 || k_out !== 4'hF) begin miscompares++; $display("FAIL clr_jk got j=%b k=%b want 0000/1111", j_out, k_out); end
        wait_done(c); mq = 0;
        vectors++; if (j_out !== 0 || k_out !== 0 || q !== 4'h0 || c !== 2) begin miscompares++; $display("FAIL clr_after got j=%b k=%b q=%b lat=%0d want 0/0/0000 lat=2", j_out, k_out, q, c); end
        step();
    endtask

    task automatic test_count_up_busy();
        logic [3:0] seq [4] = '{4'b1110, 4'b1111, 4'b0000, 4'b0001};
        int c;
        send(LD, 4'b1110, 0); wait_done(c); step();
        send(UP, 0, 3);
        cmd_valid = 1; cmd_op = CLR;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) cmd_valid = 0;
            vectors++; if (q !== seq[i] || done !== (i == 3)) begin miscompares++; $display("FAIL count_up_c%0d got q=%b done=%b want %b done=%0d", i + 1, q, done, seq[i], i == 3); end
            if (i < 3) step();
        end
        mq = 4'b0001;
        step(); step();
        vectors++; if (q !== mq || busy !== 0 || cmd_ready !== 1) begin miscompares++; $display("FAIL busy_ignore got q=%b busy=%b rdy=%b want 0001/0/1", q, busy, cmd_ready); end
    endtask

    task automatic test_count_dn_zero();
        int c;
        send(LD, 4'b0001, 0); wait_done(c); step();
        send(DN, 0, 2); step();
        vectors++; if (q !== 4'b0000) begin miscompares++; $display("FAIL count_dn1 got %b want 0000", q); end
        step();
        vectors++; if (q !== 4'b1111 || done !== 1) begin miscompares++; $display("FAIL count_dn2 got q=%b done=%b want 1111/1", q, done); end
        step();
        mq = 4'hF;
        send(UP, 0, 0); wait_done(c);
        vectors++; if (q !== mq || c !== 2) begin miscompares++; $display("FAIL count_len0 got q=%b lat=%0d want %b lat=2", q, c, mq); end
        step();
    endtask

    task automatic test_reserved();
        int c;
        send(RSV, 4'h5, 0); wait_done(c);
        vectors++; if (q !== mq || done !== 1 || err !== 1 || c !== 2) begin miscompares++; $display("FAIL reserved got q=%b done=%b err=%b lat=%0d want %b/1/1 lat=2", q, done, err, c, mq); end
        step();
        vectors++; if (err !== 0 || cmd_ready !== 1) begin miscompares++; $display("FAIL reserved_after got err=%b rdy=%b want 0/1", err, cmd_ready); end
    endtask

    task automatic test_reset_mid_count();
        int seen = 0;
        send(UP, 0, 20); step(); step();
        rst = 1;
        step();
        if (done === 1) seen++;
        step();
        rst = 0;
        mq = 0;
        vectors++; if (q !== 0 || q_bar !== 4'hF || cmd_ready !== 1 || busy !== 0) begin miscompares++; $display("FAIL rst_mid got q=%b q_bar=%b rdy=%b busy=%b want 0000/1111/1/0", q, q_bar, cmd_ready, busy); end
        for (int i = 0; i < 6; i++) begin if (done === 1) seen++; step(); end
        vectors++; if (seen !== 0 || q !== 0) begin miscompares++; $display("FAIL rst_no_done got done_pulses=%0d q=%b want 0 0000", seen, q); end
    endtask

    task automatic test_back_to_back();
        int c;
        for (int n = 0; n < 40; n++) begin
            logic [2:0] op = 3'($urandom_range(0, 7));
            logic [3:0] d = 4'($urandom);
            logic [7:0] len = 8'($urandom_range(0, 6));
            send(op, d, len); wait_done(c);
            mq = model(mq, op, d, len);
            vectors++; if (q !== mq || q_bar !== ~mq || err !== (op == RSV) || c !== latency(op, len)) begin miscompares++; $display("FAIL rand%0d op=%0d d=%b len=%0d got q=%b q_bar=%b err=%b lat=%0d want %b err=%0d lat=%0d", n, op, d, len, q, q_bar, err, c, mq, op == RSV, latency(op, len)); end
            step();
            vectors++; if (cmd_ready !== 1 || done !== 0) begin miscompares++; $display("FAIL rand%0d_idle got rdy=%b done=%b want 1/0", n, cmd_ready, done); end
        end
    endtask

`ifdef JK_BANK_CTRL_ABORT_EN
    task automatic test_abort();
        int c;
        send(CLR, 0, 0); wait_done(c); step();
        send(UP, 0, 10); step(); step();
        abort = 1;
        step();
        abort = 0;
        mq = 4'b0010;
        vectors++; if (q !== mq || done !== 1) begin miscompares++; $display("FAIL abort got q=%b done=%b want 0010/1", q, done); end
        step();
        vectors++; if (q !== mq || cmd_ready !== 1) begin miscompares++; $display("FAIL abort_after got q=%b rdy=%b want 0010/1", q, cmd_ready); end
    endtask
`endif

    initial begin
        clk = 0; rst = 1; cmd_valid = 0; cmd_op = 0; cmd_data = 0; cmd_len = 0; mq = 0;
`ifdef JK_BANK_CTRL_ABORT_EN
        abort = 0;
`endif
        test_reset();
        test_load_toggle();
        test_set_clear();
        test_count_up_busy();
        test_count_dn_zero();
        test_reserved();
        test_reset_mid_count();
        test_back_to_back();
`ifdef JK_BANK_CTRL_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/jk_bank_controller.md
Name: jk_bank_controller

Overview:
- Sequencer for a bank of WIDTH JK flip-flops. Accepts commands over a valid/ready interface and drives per-bit J/K vectors for one or more cycles.
- Commands: clear, set, toggle-mask, load, and multi-cycle up/down counting using JK toggle chains.
- The bank state is held internally and exposed as q/q_bar.
- Used wherever a JK register must be commanded by a higher-level FSM instead of raw J/K wiring.

Parameters:
- WIDTH, 4, number of JK flip-flops in the bank.
- CNT_W, 8, width of the count-length field.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block can accept a command (high only in IDLE)
- cmd_op  input  3  opcode (see Behaviour)
- cmd_data  input  WIDTH  mask for TOGGLE, value for LOAD
- cmd_len  input  CNT_W  step count for COUNT_UP/COUNT_DN
- j_out  output  WIDTH  J vector applied this cycle
- k_out  output  WIDTH  K vector applied this cycle
- q  output  WIDTH  bank state
- q_bar  output  WIDTH  always ~q
- busy  output  1  high in EXEC/COUNT/DONE
- done  output  1  one-cycle pulse on command completion
- err  output  1  one-cycle pulse with done for reserved opcode

Behaviour:
- Reset (rst=1 at posedge), values visible the following cycle: q=0, q_bar=all ones, j_out=k_out=0, state IDLE, cmd_ready=1, busy=0, done=0, err=0.
- Reset mid-operation aborts the command immediately with no done pulse.
- rst has priority over every other event.
- JK semantics per bit at each edge:
  - J=0,K=0: hold.
  - J=0,K=1: q<=0.
  - J=1,K=0: q<=1.
  - J=1,K=1: q<=~q.
- q_bar is never updated independently.
- Opcodes:
  - 000 NOP: J=K=0.
  - 001 CLEAR: J=0, K=all ones.
  - 010 SET: J=all ones, K=0.
  - 011 TOGGLE: J=K=cmd_data.
  - 100 LOAD: J=cmd_data, K=~cmd_data.
  - 101 COUNT_UP: J[i]=K[i]=AND of q[i-1:0]; bit 0 always toggles.
  - 110 COUNT_DN: J[i]=K[i]=AND of q_bar[i-1:0].
  - 111 reserved: behaves as NOP, err=1 with done.
- Handshake: transfer occurs when cmd_valid && cmd_ready at a posedge. The block latches cmd_op, cmd_data and cmd_len. cmd_valid while busy is ignored and not queued.
- FSM:
  - IDLE: cmd_ready=1. On transfer, go to COUNT for opcodes 101/110 with cmd_len!=0, otherwise to EXEC.
  - EXEC: drive the J/K for the latched op for exactly one cycle; the bank updates at this edge; then go to DONE.
  - COUNT: drive count J/K each cycle and decrement the remaining counter. Leave to DONE on the edge where the remaining counter goes 1->0, so exactly cmd_len bank updates occur.
  - DONE: J=K=0, done=1 (err=1 if reserved), go to IDLE.
- Outside EXEC/COUNT: j_out=k_out=0.
- Latency:
  - Single-cycle op accepted at edge t: j/k valid during cycle t..t+1; new q visible after edge t+1; done high in the cycle after edge t+1; cmd_ready high again after edge t+2.
  - COUNT with len L: done appears L+1 cycles after acceptance.
- COUNT with cmd_len=0: EXEC applies J=K=0 (q unchanged), then DONE.
- Wrap-around: COUNT_UP from all ones wraps to 0. COUNT_DN from 0 wraps to all ones. No flag is raised on wrap.
- A command is accepted again in the first IDLE cycle after DONE, so the minimum spacing is 3 cycles per single op.

Optional Feature:
- Macro: JK_BANK_CTRL_ABORT_EN.
- With macro defined:
  - Adds port abort (input, 1).
  - abort=1 at a posedge while in COUNT performs no bank update at that edge and moves to DONE; done pulses and q keeps its value as of before that edge.
  - abort is ignored in all other states.
- Without macro:
  - No abort port.
  - COUNT always runs the full cmd_len steps.

Test Plan (WIDTH=4, CNT_W=8):
- rst=1 for 2 cycles mid-COUNT -> q=0000, q_bar=1111, cmd_ready=1, done never pulses.
- LOAD cmd_data=1010, then TOGGLE cmd_data=0110 -> q=1010 after first done, then q=1100; q_bar=0011.
- SET then CLEAR -> q=1111, then 0000. j_out/k_out show 1111/0000, then 0000/1111, each for exactly one cycle.
- LOAD 1110, COUNT_UP cmd_len=3 -> q sequence 1111, 0000, 0001; done 4 cycles after acceptance; cmd_valid asserted during busy is ignored.
- LOAD 0001, COUNT_DN cmd_len=2 -> q 0000 then 1111. COUNT_UP cmd_len=0 -> q unchanged, done 2 cycles after acceptance.
- cmd_op=111 -> q unchanged, done=1 and err=1 in the same cycle. With JK_BANK_CTRL_ABORT_EN: COUNT_UP len=10 from 0000 with abort at the 3rd COUNT edge -> q=0010, done pulses.
